rx_frame_splitter: RTL and testbench
====================================

// Module: rx_frame_splitter
// PURPOSE
//  Per-port ingress stage of the L2 switch. Splits the MAC RX byte stream into one 128-bit header word
//  (H_FIFO) and a byte-wide body stream with end-of-frame delimiter (B_FIFO).
//  Feeds the control-frame fetcher and the forwarding engine.
//  Header is pushed only after the whole body is in B_FIFO, so consumers never underrun B_FIFO.
// PARAMETERS
//  PORT_ID   4'd0   ingress port number, placed in header[127:124]
//  MAX_BODY  1500   max body bytes per frame; excess bytes truncated
// PORTS
//  clk           in   1    clock
//  arst_n        in   1    reset, asynchronous, active-low
//  rx_valid      in   1    rx_data valid this cycle; gaps allowed; no backpressure
//  rx_data       in   8    frame byte (preamble/SFD already stripped), dst MAC first
//  rx_last       in   1    last byte of frame, qualified by rx_valid
//  rx_err        in   1    frame bad (FCS/PHY error), sampled with rx_last
//  h_fifo_din    out  128  header word
//  h_fifo_wren   out  1    header push, 1-cycle pulse
//  h_fifo_full   in   1    header FIFO full
//  b_fifo_din    out  8    body byte
//  b_fifo_del    out  1    delimiter: set on last body byte of frame
//  b_fifo_wren   out  1    body push
//  b_fifo_full   in   1    body FIFO full
//  b_fifo_afull  in   1    body FIFO free space < MAX_BODY
//  stat_frames   out  16   frames committed, saturating
//  stat_drops    out  16   frames dropped at admission or in flush, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, counters 0. No partial frame survives reset.
//  A reset mid-frame leaves B_FIFO with unterminated bytes; the FIFOs share arst_n and clear too.
//  Header layout: [127:124] PORT_ID; [123:116] 0; [115] err; [114] ctrl; [113] bcast; [112] mcast;
//   [111:64] dst MAC; [63:16] src MAC; [15:0] ethertype.
//  ctrl = dst[47:4]==44'h0180C200000. bcast = dst all ones. mcast = dst[40]. Cause is the raw dst.
//  Bytes 0..13 are captured into header registers. Bytes 14+ go to B_FIFO, registered with 1 cycle latency.
//  States:
//   S_IDLE: first rx_valid byte is the admission point.
//    If h_fifo_full or b_fifo_afull -> S_DISCARD, stat_drops++.
//    Otherwise capture byte 0 and go to S_HDR.
//   S_HDR: count bytes 1..13, then go to S_BODY.
//    rx_last before byte 13 (runt): write nothing, go to S_IDLE, stat_drops++.
//   S_BODY: push each byte. The rx_last byte sets b_fifo_del=1 and commits.
//    Frame with zero body bytes (exactly 14 bytes): push pad 8'h00 with del=1.
//    At body byte MAX_BODY without rx_last: push it with del=1, set err, go to S_DISCARD.
//    b_fifo_full at a push (contract violation): set err, drop bytes, go to S_FLUSH.
//   S_DISCARD: ignore bytes until rx_last, then go to S_IDLE. Commit the header only if the body was terminated.
//   S_FLUSH: wait until ~b_fifo_full, push 8'h00 del=1, commit with err=1, go to S_IDLE.
//    Frames starting while in S_FLUSH are discarded and counted.
//  Commit: h_fifo_din/h_fifo_wren are registered and fire in the cycle after the delimiter push; stat_frames++.
//   err = rx_err | truncation | overflow. ctrl forced 0 when err=1.
//   A first byte of the next frame in the commit cycle is accepted; the header is double-buffered.
//  Only frames counted in stat_frames produce exactly one header and exactly one delimiter.
// STRUCTURE
//  Shared include l2sw_defs.vh: header bit positions (HDR_PORT, HDR_ERR, HDR_CTRL, HDR_BCAST, HDR_MCAST,
//   HDR_DST, HDR_SRC, HDR_ETYPE), CTRL_MAC_PREFIX, state encodings.
//  Sub-module l2_dst_classifier (combinational): dst MAC -> ctrl/bcast/mcast.
// TESTING
//  1. 64-byte frame, dst 01-80-C2-00-00-01, rx_err=0.
//     -> one header, [114]=1, [115]=0; 50 body bytes, del on the 50th; stat_frames=1.
//  2. 14-byte frame, dst FF-FF-FF-FF-FF-FF.
//     -> one body byte 0x00 del=1; header [113]=1, [112]=1.
//  3. 10-byte runt.
//     -> no FIFO writes; stat_drops=1.
//  4. 1600-byte frame, MAX_BODY=1500.
//     -> 1500 body bytes, del on the 1500th; header err=1, ctrl=0; next frame handled normally.
//  5. b_fifo_afull=1 at first byte of frame.
//     -> no writes, stat_drops=1. Second frame back-to-back (no idle cycle) with afull=0 -> committed.
//  6. arst_n asserted at body byte 20.
//     -> outputs 0 next cycle; following 64-byte frame committed normally.

Source files
------------

// File: rtl/rx_frame_splitter_pkg.sv
// Shared definitions for the RX frame splitter: header layout, control MAC prefix, FSM states.
package rx_frame_splitter_pkg;

    localparam int unsigned HDR_W       = 128;
    localparam int unsigned HDR_BYTES   = 14;
    localparam int unsigned HDR_FIELDS  = 8 * HDR_BYTES;

    // Header bit positions (LSB of each field)
    localparam int unsigned HDR_PORT    = 124;
    localparam int unsigned HDR_ERR     = 115;
    localparam int unsigned HDR_CTRL    = 114;
    localparam int unsigned HDR_BCAST   = 113;
    localparam int unsigned HDR_MCAST   = 112;
    localparam int unsigned HDR_DST     = 64;
    localparam int unsigned HDR_SRC     = 16;
    localparam int unsigned HDR_ETYPE   = 0;

    localparam logic [43:0] CTRL_MAC_PREFIX = 44'h0180C200000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_DISCARD,
        S_FLUSH
    } state_t;

    // Assemble the header word from the captured dst/src/ethertype bytes and flags
    function automatic logic [HDR_W-1:0] build_header(
        input logic [3:0]            port,
        input logic                  err,
        input logic                  ctrl,
        input logic                  bcast,
        input logic                  mcast,
        input logic [HDR_FIELDS-1:0] fields
    );
        logic [HDR_W-1:0] h;
        h                   = '0;
        h[HDR_PORT +: 4]    = port;
        h[HDR_ERR]          = err;
        h[HDR_CTRL]         = ctrl;
        h[HDR_BCAST]        = bcast;
        h[HDR_MCAST]        = mcast;
        h[HDR_DST +: 48]    = fields[111:64];
        h[HDR_SRC +: 48]    = fields[63:16];
        h[HDR_ETYPE +: 16]  = fields[15:0];
        return h;
    endfunction

endpackage

// File: rtl/l2_dst_classifier.sv
// Destination MAC classifier: link-local control, broadcast and multicast flags.
module l2_dst_classifier
    import rx_frame_splitter_pkg::*;
(
    input  logic [47:0] dst,
    output logic        ctrl,
    output logic        bcast,
    output logic        mcast
);

    // Pure decode of the raw destination address
    always_comb begin
        ctrl  = (dst[47:4] == CTRL_MAC_PREFIX);
        bcast = &dst;
        mcast = dst[40];
    end

endmodule

// File: rtl/rx_frame_splitter.sv
// Per-port ingress splitter: header bytes 0..13 to one header word, remaining bytes to body FIFO.
module rx_frame_splitter
    import rx_frame_splitter_pkg::*;
#(
    parameter logic [3:0]  PORT_ID  = 4'd0,
    parameter int unsigned MAX_BODY = 1500
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_last,
    input  logic         rx_err,
    output logic [127:0] h_fifo_din,
    output logic         h_fifo_wren,
    input  logic         h_fifo_full,
    output logic [7:0]   b_fifo_din,
    output logic         b_fifo_del,
    output logic         b_fifo_wren,
    input  logic         b_fifo_full,
    input  logic         b_fifo_afull,
    output logic [15:0]  stat_frames,
    output logic [15:0]  stat_drops
);

    localparam int unsigned       CNT_W     = $clog2(MAX_BODY + 1);
    localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(HDR_BYTES - 1);
    localparam logic [CNT_W-1:0]  BODY_LAST = CNT_W'(MAX_BODY - 1);

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   frame_open, open_nxt;
    logic [HDR_FIELDS-1:0]  hdr_sr;
    logic                   commit_pend, err_pend;

    logic                   push, push_del, commit, commit_err, drop, cap;
    logic [7:0]             push_data;
    logic                   cls_ctrl, cls_bcast, cls_mcast;

    l2_dst_classifier u_cls (
        .dst   (hdr_sr[111:64]),
        .ctrl  (cls_ctrl),
        .bcast (cls_bcast),
        .mcast (cls_mcast)
    );

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (rx_valid) begin
                if (rx_last)                         state_nxt = S_IDLE;
                else if (h_fifo_full || b_fifo_afull) state_nxt = S_DISCARD;
                else                                 state_nxt = S_HDR;
            end
            S_HDR: if (rx_valid) begin
                if (rx_last)
                    state_nxt = (cnt == HDR_LAST && b_fifo_full) ? S_FLUSH : S_IDLE;
                else if (cnt == HDR_LAST)
                    state_nxt = S_BODY;
            end
            S_BODY: if (rx_valid) begin
                if (b_fifo_full)             state_nxt = S_FLUSH;
                else if (rx_last)            state_nxt = S_IDLE;
                else if (cnt == BODY_LAST)   state_nxt = S_DISCARD;
            end
            S_DISCARD: if (rx_valid && rx_last) state_nxt = S_IDLE;
            // Leave flush into discard if a frame (old tail or new arrival) is still streaming
            S_FLUSH: if (!b_fifo_full) state_nxt = open_nxt ? S_DISCARD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state actions: body push, commit request, drop count, header capture, counters
    always_comb begin
        push       = 1'b0;
        push_data  = '0;
        push_del   = 1'b0;
        commit     = 1'b0;
        commit_err = 1'b0;
        drop       = 1'b0;
        cap        = 1'b0;
        cnt_nxt    = cnt;
        open_nxt   = frame_open;
        unique case (state)
            S_IDLE: if (rx_valid) begin
                if (h_fifo_full || b_fifo_afull) begin
                    drop     = 1'b1;
                    open_nxt = ~rx_last;
                end else if (rx_last) begin
                    drop = 1'b1;
                end else begin
                    cap     = 1'b1;
                    cnt_nxt = CNT_W'(1);
                end
            end
            S_HDR: if (rx_valid) begin
                cap     = 1'b1;
                cnt_nxt = cnt + CNT_W'(1);
                if (rx_last) begin
                    if (cnt != HDR_LAST) begin
                        drop = 1'b1;
                    end else if (!b_fifo_full) begin
                        push       = 1'b1;
                        push_del   = 1'b1;
                        commit     = 1'b1;
                        commit_err = rx_err;
                    end else begin
                        open_nxt = 1'b0;
                    end
                end else if (cnt == HDR_LAST) begin
                    cnt_nxt = '0;
                end
            end
            S_BODY: if (rx_valid) begin
                if (b_fifo_full) begin
                    open_nxt = ~rx_last;
                end else begin
                    push      = 1'b1;
                    push_data = rx_data;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (rx_last) begin
                        push_del   = 1'b1;
                        commit     = 1'b1;
                        commit_err = rx_err;
                    end else if (cnt == BODY_LAST) begin
                        push_del   = 1'b1;
                        commit     = 1'b1;
                        commit_err = 1'b1;
                    end
                end
            end
            S_DISCARD: ;
            S_FLUSH: begin
                if (rx_valid) begin
                    if (frame_open) begin
                        if (rx_last) open_nxt = 1'b0;
                    end else begin
                        drop     = 1'b1;
                        open_nxt = ~rx_last;
                    end
                end
                if (!b_fifo_full) begin
                    push       = 1'b1;
                    push_del   = 1'b1;
                    commit     = 1'b1;
                    commit_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered datapath: body push, delayed header commit, statistics
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt         <= '0;
            frame_open  <= 1'b0;
            hdr_sr      <= '0;
            b_fifo_wren <= 1'b0;
            b_fifo_din  <= '0;
            b_fifo_del  <= 1'b0;
            commit_pend <= 1'b0;
            err_pend    <= 1'b0;
            h_fifo_wren <= 1'b0;
            h_fifo_din  <= '0;
            stat_frames <= '0;
            stat_drops  <= '0;
        end else begin
            cnt         <= cnt_nxt;
            frame_open  <= open_nxt;
            if (cap) hdr_sr <= {hdr_sr[HDR_FIELDS-9:0], rx_data};
            b_fifo_wren <= push;
            b_fifo_din  <= push_data;
            b_fifo_del  <= push_del;
            commit_pend <= commit;
            err_pend    <= commit_err;
            h_fifo_wren <= commit_pend;
            // hdr_sr is only overwritten by a new frame's byte 0 on this same edge, so it still
            // holds the committing frame here
            if (commit_pend) begin
                h_fifo_din <= build_header(PORT_ID, err_pend, cls_ctrl & ~err_pend,
                                           cls_bcast, cls_mcast, hdr_sr);
                if (stat_frames != '1) stat_frames <= stat_frames + 16'd1;
            end
            if (drop && stat_drops != '1) stat_drops <= stat_drops + 16'd1;
        end
    end

endmodule

// File: tb/tb_rx_frame_splitter.sv
// Self-checking bench for rx_frame_splitter: frame-level model, per-cycle FIFO write checks.
module tb_rx_frame_splitter;

    localparam logic [3:0]  PORT_ID  = 4'd5;
    localparam int unsigned MAX_BODY = 1500;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         rx_valid, rx_last, rx_err;
    logic [7:0]   rx_data;
    logic [127:0] h_fifo_din;
    logic         h_fifo_wren, h_fifo_full;
    logic [7:0]   b_fifo_din;
    logic         b_fifo_del, b_fifo_wren, b_fifo_full, b_fifo_afull;
    logic [15:0]  stat_frames, stat_drops;

    rx_frame_splitter #(.PORT_ID(PORT_ID), .MAX_BODY(MAX_BODY)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_last      (rx_last),
        .rx_err       (rx_err),
        .h_fifo_din   (h_fifo_din),
        .h_fifo_wren  (h_fifo_wren),
        .h_fifo_full  (h_fifo_full),
        .b_fifo_din   (b_fifo_din),
        .b_fifo_del   (b_fifo_del),
        .b_fifo_wren  (b_fifo_wren),
        .b_fifo_full  (b_fifo_full),
        .b_fifo_afull (b_fifo_afull),
        .stat_frames  (stat_frames),
        .stat_drops   (stat_drops)
    );

    always #5 clk = ~clk;

    int           tests = 0;
    int           fails = 0;
    logic [8:0]   exp_body[$];
    logic [127:0] exp_hdr[$];
    int           exp_frames = 0;
    int           exp_drops  = 0;
    logic [7:0]   frm[$];
    int           body_cnt = 0;
    int           hdr_cnt  = 0;
    logic [127:0] last_hdr = '0;
    logic [8:0]   last_body = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] body_byte(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // Expected header from the field rules, built with plain arithmetic
    function automatic logic [127:0] model_hdr(input logic [47:0] dst, input logic [47:0] src,
                                               input logic [15:0] et, input bit err);
        bit ctrl, bc, mc;
        logic [127:0] h;
        ctrl = ((dst >> 4) == 48'h0180C200000) && !err;
        bc   = (dst == 48'hFFFF_FFFF_FFFF);
        mc   = ((dst >> 40) & 48'h1) != 0;
        h = (128'(PORT_ID) << 124) | (128'(err) << 115) | (128'(ctrl) << 114) |
            (128'(bc) << 113) | (128'(mc) << 112) | (128'(dst) << 64) |
            (128'(src) << 16) | 128'(et);
        return h;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] et, input int total);
        logic [111:0] hb;
        hb = {dst, src, et};
        frm.delete();
        for (int i = 0; i < total; i++) begin
            if (i < 14) frm.push_back(hb[111 - 8*i -: 8]);
            else        frm.push_back(body_byte(i - 14));
        end
    endtask

    task automatic model_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] et, input int total, input bit err,
                               input bit admit);
        int nbody, npush;
        if (!admit || total < 14) begin
            exp_drops++;
            return;
        end
        nbody = total - 14;
        if (nbody == 0) begin
            exp_body.push_back(9'h100);
        end else begin
            npush = (nbody > int'(MAX_BODY)) ? int'(MAX_BODY) : nbody;
            for (int i = 0; i < npush; i++)
                exp_body.push_back({(i == npush - 1), body_byte(i)});
            if (nbody > int'(MAX_BODY)) err = 1'b1;
        end
        exp_hdr.push_back(model_hdr(dst, src, et, err));
        exp_frames++;
    endtask

    // Drive frm (first n bytes, all if n<0); caller sits at posedge+1
    task automatic send(input int n, input bit err, input bit gap, input bit afull_first);
        int lim;
        lim = (n < 0) ? frm.size() : n;
        for (int i = 0; i < lim; i++) begin
            rx_valid     = 1'b1;
            rx_data      = frm[i];
            rx_last      = (i == frm.size() - 1);
            rx_err       = (i == frm.size() - 1) ? err : 1'b0;
            b_fifo_afull = (i == 0) ? afull_first : 1'b0;
            @(posedge clk); #1;
            b_fifo_afull = 1'b0;
            if (gap && (i % 7) == 3) begin
                rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
    endtask

    task automatic end_test(input string name);
        repeat (5) @(posedge clk);
        #1;
        check({name, "_body_left"}, 128'(exp_body.size()), 128'd0);
        check({name, "_hdr_left"},  128'(exp_hdr.size()),  128'd0);
        check({name, "_frames"},    128'(stat_frames),     128'(exp_frames));
        check({name, "_drops"},     128'(stat_drops),      128'(exp_drops));
    endtask

    // Per-cycle compare of every FIFO write against the model queues
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (b_fifo_wren) begin
                    body_cnt++;
                    last_body = {b_fifo_del, b_fifo_din};
                    if (exp_body.size() == 0) check("body_extra", 128'd1, 128'd0);
                    else check("body", 128'({b_fifo_del, b_fifo_din}), 128'(exp_body.pop_front()));
                end
                if (h_fifo_wren) begin
                    hdr_cnt++;
                    last_hdr = h_fifo_din;
                    if (exp_hdr.size() == 0) check("hdr_extra", 128'd1, 128'd0);
                    else check("hdr", h_fifo_din, exp_hdr.pop_front());
                end
            end
        end
    endtask

    int b0, h0;

    initial begin
        arst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0; rx_err = 1'b0;
        h_fifo_full = 1'b0; b_fifo_full = 1'b0; b_fifo_afull = 1'b0;
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        check("reset_outs", {h_fifo_din, 8'(h_fifo_wren), b_fifo_din, 8'(b_fifo_del),
                             8'(b_fifo_wren), stat_frames, stat_drops} != '0 ? 128'd1 : 128'd0, 128'd0);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // 1: 64-byte control frame with gaps
        b0 = body_cnt; h0 = hdr_cnt;
        build_frame(48'h0180C2000001, 48'h001122334455, 16'h0800, 64);
        model_frame(48'h0180C2000001, 48'h001122334455, 16'h0800, 64, 1'b0, 1'b1);
        send(-1, 1'b0, 1'b1, 1'b0);
        end_test("t1");
        check("t1_hdr_lit",  last_hdr, 128'h5005_0180C2000001_001122334455_0800);
        check("t1_nbody",    128'(body_cnt - b0), 128'd50);
        check("t1_last_del", 128'(last_body[8]), 128'd1);
        check("t1_nhdr",     128'(hdr_cnt - h0), 128'd1);

        // 2: 14-byte broadcast frame -> pad byte
        b0 = body_cnt;
        build_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h88B5, 14);
        model_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h88B5, 14, 1'b0, 1'b1);
        send(-1, 1'b0, 1'b0, 1'b0);
        end_test("t2");
        check("t2_flags", 128'(last_hdr[127:112]), 128'h5003);
        check("t2_pad",   128'(last_body), 128'h100);
        check("t2_nbody", 128'(body_cnt - b0), 128'd1);

        // 3: 10-byte runt
        b0 = body_cnt; h0 = hdr_cnt;
        build_frame(48'h000102030405, 48'h0A0B0C0D0E0F, 16'h0800, 10);
        model_frame(48'h000102030405, 48'h0A0B0C0D0E0F, 16'h0800, 10, 1'b0, 1'b1);
        send(-1, 1'b0, 1'b0, 1'b0);
        end_test("t3");
        check("t3_writes", 128'((body_cnt - b0) + (hdr_cnt - h0)), 128'd0);
        check("t3_drops",  128'(stat_drops), 128'd1);

        // 4: 1600-byte frame truncated, then an errored control frame
        b0 = body_cnt;
        build_frame(48'h020000000001, 48'h001122334455, 16'h0800, 1600);
        model_frame(48'h020000000001, 48'h001122334455, 16'h0800, 1600, 1'b0, 1'b1);
        send(-1, 1'b0, 1'b0, 1'b0);
        end_test("t4a");
        check("t4_nbody", 128'(body_cnt - b0), 128'd1500);
        check("t4_flags", 128'(last_hdr[127:112]), 128'h5008);
        build_frame(48'h0180C200000E, 48'h001122334455, 16'h0800, 64);
        model_frame(48'h0180C200000E, 48'h001122334455, 16'h0800, 64, 1'b1, 1'b1);
        send(-1, 1'b1, 1'b0, 1'b0);
        end_test("t4b");
        check("t4b_flags", 128'(last_hdr[127:112]), 128'h5009);

        // 5: afull at admission, then back-to-back good frame
        b0 = body_cnt;
        build_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 64);
        model_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 64, 1'b0, 1'b0);
        send(-1, 1'b0, 1'b0, 1'b1);
        model_frame(48'h00AABBCCDDEE, 48'h001122334455, 16'h0800, 64, 1'b0, 1'b1);
        send(-1, 1'b0, 1'b0, 1'b0);
        end_test("t5");
        check("t5_nbody",  128'(body_cnt - b0), 128'd50);
        check("t5_drops",  128'(stat_drops),  128'd2);
        check("t5_frames", 128'(stat_frames), 128'd5);
        check("t5_flags",  128'(last_hdr[127:112]), 128'h5000);

        // 6: reset at body byte 20, then a normal frame
        build_frame(48'h0180C2000002, 48'h001122334455, 16'h0800, 64);
        model_frame(48'h0180C2000002, 48'h001122334455, 16'h0800, 64, 1'b0, 1'b1);
        send(34, 1'b0, 1'b0, 1'b0);
        arst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_outs", {h_fifo_din, 8'(h_fifo_wren), b_fifo_din, 8'(b_fifo_del),
                              8'(b_fifo_wren), stat_frames, stat_drops} != '0 ? 128'd1 : 128'd0, 128'd0);
        exp_body.delete(); exp_hdr.delete();
        exp_frames = 0; exp_drops = 0;
        arst_n = 1'b1;
        @(posedge clk); #1;
        b0 = body_cnt;
        model_frame(48'h0180C2000002, 48'h001122334455, 16'h0800, 64, 1'b0, 1'b1);
        send(-1, 1'b0, 1'b0, 1'b0);
        end_test("t6");
        check("t6_nbody",  128'(body_cnt - b0), 128'd50);
        check("t6_frames", 128'(stat_frames), 128'd1);
        check("t6_flags",  128'(last_hdr[127:112]), 128'h5005);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
